// File: rtl/param_ram_clr.sv
// rtl/param_ram_clr.sv - single-port byte-maskable RAM with registered read and clear engine
//
// Purpose:
//   Single-port synchronous RAM with:
//   - per-byte write enables;
//   - a registered read with a one-cycle valid strobe;
//   - a sequential clear engine that fills every word with CLR_VALUE.
//   The clear engine runs after reset and after a clr request.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset, starts a full clear
//   ena       access request (dropped while busy)
//   wena      1 = write, 0 = read
//   addr      word address
//   byte_en   write byte mask, bit i covers data bits [8i+7:8i]
//   data_in   write data
//   clr       clear request, honoured only when idle
//   data_out  registered read data, holds between reads
//   rd_valid  one-cycle pulse marking a new data_out value
//   busy      clear engine running
module param_ram_clr #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic                      wena,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH/8-1:0]   byte_en,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      clr,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      rd_valid,
    output logic                      busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    rd_valid_q, rd_valid_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [NB-1:0]           mem_wbe;

    wire clr_last = (clr_ptr_q == {ADDR_WIDTH{1'b1}});

    // State register; all control flops reset here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_last) state_d = ST_IDLE;
            ST_IDLE:  if (clr)      state_d = ST_CLEAR;
            default:                state_d = ST_CLEAR;
        endcase
    end

    // Output / datapath control.
    always_comb begin
        busy       = (state_q == ST_CLEAR);
        clr_ptr_d  = clr_ptr_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = addr;
        mem_wdata  = data_in;
        mem_wbe    = byte_en;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = CLR_VALUE;
                mem_wbe   = '1;
                // Wraps to zero on the exit write, ready for the next clear.
                clr_ptr_d = clr_ptr_q + 1'b1;
            end
            default: begin
                if (clr) begin
                    // Clear wins over a same-cycle access; the access is dropped.
                    clr_ptr_d = '0;
                end else if (ena && wena) begin
                    mem_we = 1'b1;
                end else if (ena) begin
                    data_out_d = mem[addr];
                    rd_valid_d = 1'b1;
                end
            end
        endcase
    end

    // Storage array, no reset; contents are defined by the clear engine.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_wbe[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_param_ram_clr.sv
// tb/tb_param_ram_clr.sv - self-checking bench for param_ram_clr
module tb_param_ram_clr;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam logic [DW-1:0] CLRV = 32'h0;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ena = 1'b0;
    logic          wena = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [3:0]    byte_en = '0;
    logic [DW-1:0] data_in = '0;
    logic          clr = 1'b0;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_dout;

    param_ram_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLR_VALUE(CLRV)) dut (
        .clk(clk), .rst(rst), .ena(ena), .wena(wena), .addr(addr),
        .byte_en(byte_en), .data_in(data_in), .clr(clr),
        .data_out(data_out), .rd_valid(rd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = CLRV;
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [3:0] be, input logic [DW-1:0] d);
        for (int i = 0; i < 4; i++)
            if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [3:0] be, input logic [DW-1:0] d);
        ena = 1'b1; wena = 1'b1; addr = a; byte_en = be; data_in = d;
        step();
        ena = 1'b0; wena = 1'b0;
        model_write(a, be, d);
        total++;
        if (rd_valid !== 1'b0 || data_out !== ref_dout) begin
            bad++;
            $display("FAIL write_side_effect a=%0d rd_valid=%b data_out=%h expected rd_valid=0 data_out=%h",
                     a, rd_valid, data_out, ref_dout);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input string tag);
        ena = 1'b1; wena = 1'b0; addr = a;
        step();
        ena = 1'b0;
        ref_dout = ref_mem[a];
        total++;
        if (rd_valid !== 1'b1 || data_out !== ref_dout) begin
            bad++;
            $display("FAIL %s a=%0d rd_valid=%b data_out=%h expected rd_valid=1 data_out=%h",
                     tag, a, rd_valid, data_out, ref_dout);
        end
    endtask

    // Counts busy cycles (including the current sample) until idle, bounded.
    // Optionally hammers the RAM with accesses that must be ignored.
    task automatic count_busy(input int expected, input bit hammer, input string tag);
        int cnt = 0;
        int noisy = 0;
        while (busy === 1'b1 && cnt < 200) begin
            if (hammer) begin
                ena = 1'b1; wena = $urandom_range(0, 1); addr = '0;
                byte_en = 4'hF; data_in = $urandom | 32'h1;
            end
            cnt++;
            step();
            if (hammer && busy === 1'b1 && rd_valid !== 1'b0) noisy++;
        end
        ena = 1'b0; wena = 1'b0;
        total++;
        if (cnt !== expected) begin
            bad++;
            $display("FAIL %s_busy_cycles got=%0d expected=%0d", tag, cnt, expected);
        end
        if (hammer) begin
            total++;
            if (noisy !== 0) begin
                bad++;
                $display("FAIL %s_rd_valid_while_busy got=%0d expected=0", tag, noisy);
            end
        end
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ref_dout = '0;
        total++;
        if (busy !== 1'b1 || rd_valid !== 1'b0 || data_out !== '0) begin
            bad++;
            $display("FAIL reset_state busy=%b rd_valid=%b data_out=%h expected 1 0 0", busy, rd_valid, data_out);
        end
        count_busy(DEPTH, 1'b0, "reset");
        do_read(5'd0, "reset_read0");
        do_read(5'd17, "reset_read17");
        do_read(5'd31, "reset_read31");
        step();
        total++;
        if (rd_valid !== 1'b0 || data_out !== ref_dout) begin
            bad++;
            $display("FAIL idle_hold rd_valid=%b data_out=%h expected 0 %h", rd_valid, data_out, ref_dout);
        end
    endtask

    task automatic test_write_read();
        do_write(5'd5, 4'hF, 32'hDEADBEEF);
        do_read(5'd5, "write_read");
        total++;
        if (data_out !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL write_read_const got=%h expected=deadbeef", data_out);
        end
    endtask

    task automatic test_byte_mask();
        do_write(5'd5, 4'b0101, 32'h11223344);
        do_read(5'd5, "byte_mask");
        total++;
        if (data_out !== 32'hDE22BE44) begin
            bad++;
            $display("FAIL byte_mask_const got=%h expected=de22be44", data_out);
        end
        do_write(5'd5, 4'b0000, 32'hFFFFFFFF);
        do_read(5'd5, "byte_mask_zero");
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) do_write(AW'(i), 4'hF, 32'hA0 + i);
        ena = 1'b1; wena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr = AW'(i);
            step();
            total++;
            if (rd_valid !== 1'b1 || data_out !== 32'hA0 + i) begin
                bad++;
                $display("FAIL stream_%0d rd_valid=%b data_out=%h expected 1 %h", i, rd_valid, data_out, 32'hA0 + i);
            end
        end
        ena = 1'b0;
        ref_dout = 32'hA2;
        step();
        total++;
        if (rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_end rd_valid=%b expected 0", rd_valid);
        end
    endtask

    task automatic test_clr_vs_access();
        do_write(5'd3, 4'hF, 32'h12345678);
        ena = 1'b1; wena = 1'b1; addr = 5'd3; byte_en = 4'hF; data_in = 32'hCAFEF00D; clr = 1'b1;
        step();
        clr = 1'b0; ena = 1'b0; wena = 1'b0;
        total++;
        if (busy !== 1'b1 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL clr_start busy=%b rd_valid=%b expected 1 0", busy, rd_valid);
        end
        count_busy(DEPTH, 1'b1, "clr");
        do_read(5'd3, "clr_addr3");
        do_read(5'd0, "clr_addr0_untouched");
    endtask

    task automatic test_reset_mid_clear();
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ref_dout = '0;
        count_busy(DEPTH, 1'b0, "rst_mid_clear");
        do_read(5'd31, "rst_mid_clear_read");
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 1)) do_write(a, 4'($urandom), $urandom);
            else                      do_read(a, "random_read");
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_stream();
        test_clr_vs_access();
        test_reset_mid_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
